// File: rtl/trap_ctrl_if.sv
// Commit/CSR/redirect bundle between the pipeline and the machine-mode trap sequencer.
interface trap_ctrl_if;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [31:0] commit_npc;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic        exc_ecall;
  logic [31:0] exc_tval;
  logic        mret_valid;
  logic        irq_mei;
  logic        irq_mti;
  logic        irq_msi;
  logic [11:0] csr_addr;
  logic        csr_wen;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic [1:0]  priv;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport slave (
    input  commit_valid, commit_pc, commit_npc, exc_valid, exc_code, exc_ecall, exc_tval,
           mret_valid, irq_mei, irq_mti, irq_msi, csr_addr, csr_wen, csr_wdata, redirect_ready,
    output csr_rdata, csr_hit, priv, busy, redirect_valid, redirect_pc
  );

  modport master (
    output commit_valid, commit_pc, commit_npc, exc_valid, exc_code, exc_ecall, exc_tval,
           mret_valid, irq_mei, irq_mti, irq_msi, csr_addr, csr_wen, csr_wdata, redirect_ready,
    input  csr_rdata, csr_hit, priv, busy, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: exception/interrupt entry, mret, one fetch redirect per event.
// Optional macro VECTORED_MODE_EN enables mtvec.MODE and vectored interrupt targets.
module trap_ctrl #(
  parameter logic [31:0] RESET_TVEC = 32'h0000_0000
) (
  input logic        clock,
  input logic        reset,
  trap_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ENTER, S_RETURN, S_FLUSH} state_t;

  localparam logic [1:0]  PRIV_U     = 2'b00;
  localparam logic [1:0]  PRIV_M     = 2'b11;
  localparam logic [11:0] CSR_MSTAT  = 12'h300;
  localparam logic [11:0] CSR_MIE    = 12'h304;
  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;
  localparam logic [11:0] CSR_MIP    = 12'h344;
`ifdef VECTORED_MODE_EN
  localparam logic [31:0] TVEC_MASK  = 32'hFFFF_FFFD;
`else
  localparam logic [31:0] TVEC_MASK  = 32'hFFFF_FFFC;
`endif

  state_t      r_state, w_next;
  logic [1:0]  r_priv, r_mpp;
  logic        r_mstat_mie, r_mpie;
  logic [2:0]  r_mie;          // {MEIE, MTIE, MSIE}
  logic [31:0] r_mtvec, r_mepc, r_mcause, r_mtval, r_target;
  logic        r_pint;
  logic [3:0]  r_pcode;
  logic [31:0] r_pepc, r_ptval;
  logic        r_rv;

  logic [2:0]  w_pend;
  logic        w_irq, w_idle, w_take_exc, w_take_mret, w_take_irq, w_event, w_csr_we;
  logic [3:0]  w_exc_code, w_irq_code;
  logic [31:0] w_trap_target;

  assign w_idle      = (r_state == S_IDLE);
  assign w_pend      = {bus.irq_mei, bus.irq_mti, bus.irq_msi} & r_mie;
  assign w_irq       = (|w_pend) && ((r_priv == PRIV_U) || r_mstat_mie);
  assign w_take_exc  = w_idle && bus.commit_valid && bus.exc_valid;
  assign w_take_mret = w_idle && bus.commit_valid && !bus.exc_valid && bus.mret_valid;
  assign w_take_irq  = w_idle && bus.commit_valid && !bus.exc_valid && !bus.mret_valid && w_irq;
  assign w_event     = w_take_exc || w_take_mret || w_take_irq;
  assign w_csr_we    = w_idle && bus.csr_wen && !w_event;
  assign w_exc_code  = bus.exc_ecall ? ((r_priv == PRIV_U) ? 4'd8 : 4'd11) : bus.exc_code;
  assign w_irq_code  = w_pend[2] ? 4'd11 : (w_pend[0] ? 4'd3 : 4'd7);

  always_comb begin
    w_trap_target = {r_mtvec[31:2], 2'b00};
`ifdef VECTORED_MODE_EN
    if (r_pint && r_mtvec[0]) w_trap_target = w_trap_target + {26'b0, r_pcode, 2'b00};
`endif
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_take_exc || w_take_irq) w_next = S_ENTER;
        else if (w_take_mret)         w_next = S_RETURN;
      end
      S_ENTER, S_RETURN: w_next = S_FLUSH;
      // redirect_valid drops one cycle before IDLE, giving the fetch side a clean gap
      S_FLUSH: if (!r_rv) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_priv      <= PRIV_M;
      r_mstat_mie <= 1'b0;
      r_mpie      <= 1'b0;
      r_mpp       <= PRIV_M;
      r_mie       <= '0;
      r_mtvec     <= RESET_TVEC & TVEC_MASK;
      r_mepc      <= '0;
      r_mcause    <= '0;
      r_mtval     <= '0;
      r_target    <= '0;
      r_pint      <= 1'b0;
      r_pcode     <= '0;
      r_pepc      <= '0;
      r_ptval     <= '0;
      r_rv        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_take_exc) begin
        r_pint  <= 1'b0;
        r_pcode <= w_exc_code;
        r_pepc  <= {bus.commit_pc[31:2], 2'b00};
        r_ptval <= bus.exc_tval;
      end else if (w_take_irq) begin
        r_pint  <= 1'b1;
        r_pcode <= w_irq_code;
        r_pepc  <= {bus.commit_npc[31:2], 2'b00};
        r_ptval <= '0;
      end
      unique case (r_state)
        S_ENTER: begin
          r_mcause    <= {r_pint, 27'b0, r_pcode};
          r_mepc      <= r_pepc;
          r_mtval     <= r_ptval;
          r_mpie      <= r_mstat_mie;
          r_mstat_mie <= 1'b0;
          r_mpp       <= r_priv;
          r_priv      <= PRIV_M;
          r_target    <= w_trap_target;
          r_rv        <= 1'b1;
        end
        S_RETURN: begin
          r_priv      <= r_mpp;
          r_mstat_mie <= r_mpie;
          r_mpie      <= 1'b1;
          r_mpp       <= PRIV_U;
          r_target    <= r_mepc;
          r_rv        <= 1'b1;
        end
        S_FLUSH: if (r_rv && bus.redirect_ready) r_rv <= 1'b0;
        default: ;
      endcase
      if (w_csr_we) begin
        unique case (bus.csr_addr)
          CSR_MSTAT: begin
            r_mstat_mie <= bus.csr_wdata[3];
            r_mpie      <= bus.csr_wdata[7];
            r_mpp       <= (bus.csr_wdata[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
          end
          CSR_MIE:    r_mie    <= {bus.csr_wdata[11], bus.csr_wdata[7], bus.csr_wdata[3]};
          CSR_MTVEC:  r_mtvec  <= bus.csr_wdata & TVEC_MASK;
          CSR_MEPC:   r_mepc   <= {bus.csr_wdata[31:2], 2'b00};
          CSR_MCAUSE: r_mcause <= {bus.csr_wdata[31], 27'b0, bus.csr_wdata[3:0]};
          CSR_MTVAL:  r_mtval  <= bus.csr_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.csr_rdata = '0;
    bus.csr_hit   = 1'b1;
    unique case (bus.csr_addr)
      CSR_MSTAT:  bus.csr_rdata = {19'b0, r_mpp, 3'b000, r_mpie, 3'b000, r_mstat_mie, 3'b000};
      CSR_MIE:    bus.csr_rdata = {20'b0, r_mie[2], 3'b000, r_mie[1], 3'b000, r_mie[0], 3'b000};
      CSR_MTVEC:  bus.csr_rdata = r_mtvec;
      CSR_MEPC:   bus.csr_rdata = r_mepc;
      CSR_MCAUSE: bus.csr_rdata = r_mcause;
      CSR_MTVAL:  bus.csr_rdata = r_mtval;
      CSR_MIP:    bus.csr_rdata = {20'b0, bus.irq_mei, 3'b000, bus.irq_mti, 3'b000, bus.irq_msi, 3'b000};
      default:    bus.csr_hit   = 1'b0;
    endcase
  end

  assign bus.priv           = r_priv;
  assign bus.busy           = !w_idle;
  assign bus.redirect_valid = r_rv;
  assign bus.redirect_pc    = r_target;
endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized scoreboard bench for trap_ctrl against an architectural trap model.
module tb_trap_ctrl;
  localparam logic [31:0] TVEC = 32'h1000_0000;
`ifdef VECTORED_MODE_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  trap_ctrl_if tif();
  trap_ctrl #(.RESET_TVEC(TVEC)) dut (.clock(clk), .reset(rst), .bus(tif));
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  bit hold_low = 1'b0;
  bit rand_ready = 1'b0;

  // architectural model
  logic [1:0]  m_priv, m_mpp;
  bit          m_mie_b, m_mpie;
  logic [31:0] m_mie, m_mtvec, m_mepc, m_mcause, m_mtval;
  logic [2:0]  m_irq;  // {mei, mti, msi}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_priv = 2'd3; m_mpp = 2'd3; m_mie_b = 0; m_mpie = 0; m_mie = 0;
    m_mtvec = VEC ? (TVEC & ~32'h2) : (TVEC & ~32'h3);
    m_mepc = 0; m_mcause = 0; m_mtval = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a, output bit hit);
    hit = 1;
    case (a)
      12'h300: return (32'(m_mpp) << 11) | (32'(m_mpie) << 7) | (32'(m_mie_b) << 3);
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return (32'(m_irq[2]) << 11) | (32'(m_irq[1]) << 7) | (32'(m_irq[0]) << 3);
      default: begin hit = 0; return 0; end
    endcase
  endfunction

  function automatic void model_write(input logic [11:0] a, input logic [31:0] d);
    case (a)
      12'h300: begin
        m_mie_b = d[3]; m_mpie = d[7];
        m_mpp = (d[12:11] == 2'd3) ? 2'd3 : 2'd0;
      end
      12'h304: m_mie = d & 32'h888;
      12'h305: m_mtvec = VEC ? (d & ~32'h2) : (d & ~32'h3);
      12'h341: m_mepc = d & ~32'h3;
      12'h342: m_mcause = d & 32'h8000_000F;
      12'h343: m_mtval = d;
      default: ;
    endcase
  endfunction

  function automatic void model_enter(input int code, input logic [31:0] epc,
                                      input logic [31:0] tval, input bit intr);
    logic [31:0] tgt;
    m_mcause = intr ? (32'h8000_0000 | 32'(code)) : 32'(code);
    m_mepc = epc & ~32'h3;
    m_mtval = tval;
    m_mpie = m_mie_b; m_mie_b = 0; m_mpp = m_priv; m_priv = 2'd3;
    tgt = m_mtvec & ~32'h3;
    if (intr && VEC && m_mtvec[0]) tgt = tgt + 32'(4 * code);
    exp_q.push_back(tgt);
  endfunction

  // drives one cycle of commit/CSR inputs and updates the model
  task automatic drive(input bit cv, input bit exc, input logic [3:0] code, input bit ecall,
                       input logic [31:0] tval, input bit mret, input logic [31:0] pc,
                       input logic [31:0] npc, input logic [2:0] irq, input bit wen,
                       input logic [11:0] a, input logic [31:0] wd);
    logic [31:0] pend;
    bit ev;
    @(posedge clk); #1;
    tif.commit_valid = cv; tif.exc_valid = exc; tif.exc_code = code; tif.exc_ecall = ecall;
    tif.exc_tval = tval; tif.mret_valid = mret; tif.commit_pc = pc; tif.commit_npc = npc;
    {tif.irq_mei, tif.irq_mti, tif.irq_msi} = irq;
    tif.csr_wen = wen; tif.csr_addr = a; tif.csr_wdata = wd;
    m_irq = irq;
    pend = ((32'(irq[2]) << 11) | (32'(irq[1]) << 7) | (32'(irq[0]) << 3)) & m_mie;
    ev = 0;
    if (cv && exc) begin
      ev = 1;
      model_enter(ecall ? ((m_priv == 2'd0) ? 8 : 11) : int'(code), pc, tval, 0);
    end else if (cv && mret) begin
      ev = 1;
      exp_q.push_back(m_mepc);
      m_priv = m_mpp; m_mie_b = m_mpie; m_mpie = 1; m_mpp = 2'd0;
    end else if (cv && pend != 0 && (m_priv == 2'd0 || m_mie_b)) begin
      ev = 1;
      model_enter(pend[11] ? 11 : (pend[3] ? 3 : 7), npc, 0, 1);
    end
    if (!ev && wen) model_write(a, wd);
    @(posedge clk); #1;
    tif.commit_valid = 0; tif.exc_valid = 0; tif.mret_valid = 0; tif.exc_ecall = 0; tif.csr_wen = 0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (!tif.busy) return;
    end
    checks++; errors++;
    $display("FAIL idle_timeout actual=busy required=idle");
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    drive(0, 0, 0, 0, 0, 0, 0, 0, m_irq, 1, a, d);
  endtask

  task automatic commit(input bit exc, input logic [3:0] code, input bit ecall, input logic [31:0] tval,
                        input bit mret, input logic [31:0] pc, input logic [2:0] irq);
    drive(1, exc, code, ecall, tval, mret, pc, pc + 4, irq, 0, 0, 0);
    wait_idle();
  endtask

  task automatic csr_chk(input logic [11:0] a);
    logic [31:0] e;
    bit h;
    @(posedge clk); #1;
    tif.csr_addr = a;
    @(negedge clk);
    e = model_read(a, h);
    check($sformatf("csr_%h", a), tif.csr_rdata, e);
    check($sformatf("hit_%h", a), 32'(tif.csr_hit), 32'(h));
  endtask

  task automatic check_all();
    logic [11:0] addrs [8] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7C0};
    foreach (addrs[i]) csr_chk(addrs[i]);
    check("priv", 32'(tif.priv), 32'(m_priv));
  endtask

  always @(posedge clk) begin
    #1;
    tif.redirect_ready = hold_low ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // monitor: handshake pops the scoreboard; a stalled redirect must hold its value
  bit stall_pending = 0;
  logic [31:0] stall_pc;
  always @(negedge clk) begin
    if (rst) begin
      stall_pending = 0;
    end else begin
      if (stall_pending) begin
        check("redirect_hold_valid", 32'(tif.redirect_valid), 32'd1);
        check("redirect_hold_pc", tif.redirect_pc, stall_pc);
      end
      stall_pending = tif.redirect_valid && !tif.redirect_ready;
      stall_pc = tif.redirect_pc;
      if (tif.redirect_valid && tif.redirect_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL redirect_unexpected actual=%h required=none", tif.redirect_pc);
        end else begin
          check("redirect_pc", tif.redirect_pc, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [11:0] raddrs [9] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h123, 12'h300};
    tif.commit_valid = 0; tif.commit_pc = 0; tif.commit_npc = 0; tif.exc_valid = 0;
    tif.exc_code = 0; tif.exc_ecall = 0; tif.exc_tval = 0; tif.mret_valid = 0;
    tif.irq_mei = 0; tif.irq_mti = 0; tif.irq_msi = 0; tif.csr_addr = 12'h300;
    tif.csr_wen = 0; tif.csr_wdata = 0; tif.redirect_ready = 1;
    m_irq = 0;
    model_reset();

    // reset values
    repeat (2) @(negedge clk);
    check("rst_mstatus", tif.csr_rdata, 32'h0000_1800);
    check("rst_priv", 32'(tif.priv), 32'd3);
    check("rst_rv", 32'(tif.redirect_valid), 32'd0);
    check("rst_busy", 32'(tif.busy), 32'd0);
    @(posedge clk); #1; rst = 0;
    csr_chk(12'h305);

    // exception entry, with trap latency and busy length
    csr_wr(12'h305, 32'h100);
    drive(1, 1, 4'd2, 0, 32'h13, 0, 32'h40, 32'h44, 0, 0, 0, 0);
    @(negedge clk); check("lat_rv_c1", 32'(tif.redirect_valid), 0); check("lat_busy_c1", 32'(tif.busy), 1);
    @(negedge clk); check("lat_rv_c2", 32'(tif.redirect_valid), 1); check("lat_pc_c2", tif.redirect_pc, 32'h100);
    @(negedge clk); check("lat_rv_c3", 32'(tif.redirect_valid), 0); check("lat_busy_c3", 32'(tif.busy), 1);
    @(negedge clk); check("lat_busy_c4", 32'(tif.busy), 0);
    check_all();
    check("t2_mcause", m_mcause, 32'd2);

    // u-mode ecall then mret
    csr_wr(12'h300, 32'h0000_0080);
    csr_wr(12'h341, 32'h200);
    commit(0, 0, 0, 0, 1, 32'h10, 0);
    check("t3_priv_u", 32'(tif.priv), 32'd0);
    commit(1, 4'd5, 1, 0, 0, 32'h80, 0);
    check_all();
    commit(0, 0, 0, 0, 1, 32'h90, 0);
    check_all();

    // interrupt priority: MEI beats MSI and MTI
    csr_wr(12'h300, 32'h1808);
    csr_wr(12'h304, 32'hFFFF_FFFF);
    commit(0, 0, 0, 0, 0, 32'h20, 3'b111);
    check_all();
    csr_wr(12'h300, 32'h1808);
    commit(0, 0, 0, 0, 0, 32'h30, 3'b011);
    check_all();

    // exception beats mret and irq; redirect held under back-pressure
    csr_wr(12'h300, 32'h1808);
    hold_low = 1;
    drive(1, 1, 4'd4, 0, 32'hAB, 1, 32'h60, 32'h64, 3'b111, 0, 0, 0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (n >= 1) check("t5_busy", 32'(tif.busy), 1);
    end
    hold_low = 0;
    wait_idle();
    check_all();

    // vectored interrupt target (base only without vectoring)
    csr_wr(12'h305, 32'h201);
    csr_wr(12'h304, 32'h080);
    csr_wr(12'h300, 32'h1808);
    csr_chk(12'h305);
    commit(0, 0, 0, 0, 0, 32'h70, 3'b010);
    check("t6_vec_mepc", m_mepc, 32'h74);
    check_all();

    // event in the same cycle as a CSR write drops the write
    csr_wr(12'h300, 32'h1808);
    drive(1, 0, 0, 0, 0, 0, 32'h90, 32'h94, 3'b010, 1, 12'h343, 32'hDEAD);
    wait_idle();
    check_all();

    // reset while a redirect is pending
    hold_low = 1;
    drive(1, 1, 4'd1, 0, 0, 0, 32'h50, 32'h54, 0, 0, 0, 0);
    @(negedge clk); @(negedge clk);
    rst = 1; #1;
    check("midrst_rv", 32'(tif.redirect_valid), 0);
    check("midrst_busy", 32'(tif.busy), 0);
    exp_q.delete();
    model_reset();
    hold_low = 0;
    @(posedge clk); #1; rst = 0;
    check_all();

    // randomized traffic with random fetch back-pressure
    rand_ready = 1;
    for (int it = 0; it < 300; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        csr_wr(raddrs[$urandom_range(0, 8)], $urandom());
      end else if (op <= 3) begin
        csr_chk(raddrs[$urandom_range(0, 8)]);
      end else begin
        drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, 4'($urandom()),
              $urandom_range(0, 2) == 0, $urandom(), $urandom_range(0, 3) == 0,
              $urandom(), $urandom(), 3'($urandom()), $urandom_range(0, 2) == 0,
              raddrs[$urandom_range(0, 8)], $urandom());
        wait_idle();
        check("rnd_priv", 32'(tif.priv), 32'(m_priv));
      end
    end
    rand_ready = 0;
    check_all();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
